pgm_tb_sched: RTL and testbench

PGM_TB_SCHED -- requirements
Module: pgm_tb_sched

---
 rtl/pgm_tb_sched.sv | 138 +++++++++++++
 tb/tb_pgm_tb_sched.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pgm_tb_sched.sv
// Token-bucket replay scheduler for the packet-store test path.
// Grants one packet at a time, debiting tokens that refill on a timer.
module pgm_tb_sched #(
  parameter int TW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_wr,
  input  logic [1:0]    cfg_addr,
  input  logic [31:0]   cfg_wdata,
  input  logic          start_flag,
  input  logic          finish_flag,
  input  logic          send_req,
  input  logic [7:0]    pkt_len,
  input  logic          in_alf,
  output logic          send_grant,
  input  logic          send_done,
  output logic [TW-1:0] bucket_level,
  output logic [31:0]   grant_cnt,
  output logic [1:0]    sched_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    XMIT = 2'd2,
    STOP = 2'd3
  } state_e;

  state_e        st_q, st_d;
  logic [TW-1:0] per_q, per_d;
  logic [TW-1:0] amt_q, amt_d;
  logic [TW-1:0] dep_q, dep_d;
  logic [TW-1:0] bkt_q, bkt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [31:0]   gcnt_q, gcnt_d;
  logic          grant_q, grant_d;

  logic [TW-1:0] per_eff;
  logic [TW-1:0] len_ext;
  logic [TW-1:0] cost;
  logic          active;
  logic          tick;
  logic          grant;
  logic [TW:0]   sum;

  always_comb begin
    per_eff = (per_q == '0) ? TW'(1) : per_q;
    len_ext = TW'(pkt_len);
    cost    = (len_ext == '0) ? TW'(1) : len_ext;
    if (cost > dep_q) cost = dep_q;
    active  = (st_q != IDLE);
    tick    = active && (tmr_q == per_eff - TW'(1));
    grant   = (st_q == RUN) && send_req && !in_alf
              && !finish_flag && (bkt_q >= cost);
    // One extra bit keeps bucket+refill from wrapping before the clamp
    sum     = {1'b0, bkt_q}
              - (grant ? {1'b0, cost} : '0)
              + (tick ? {1'b0, amt_q} : '0);
  end

  always_comb begin
    st_d    = st_q;
    per_d   = per_q;
    amt_d   = amt_q;
    dep_d   = dep_q;
    bkt_d   = bkt_q;
    tmr_d   = tmr_q;
    gcnt_d  = gcnt_q;
    grant_d = grant;

    if (active) begin
      tmr_d = tick ? '0 : tmr_q + TW'(1);
      bkt_d = (sum > {1'b0, dep_q}) ? dep_q : sum[TW-1:0];
    end
    if (grant) gcnt_d = gcnt_q + 32'd1;

    if (st_q == IDLE && cfg_wr) begin
      case (cfg_addr)
        2'd0:    per_d = cfg_wdata[TW-1:0];
        2'd1:    amt_d = cfg_wdata[TW-1:0];
        2'd2:    dep_d = cfg_wdata[TW-1:0];
        default: ;
      endcase
    end

    unique case (st_q)
      IDLE: begin
        if (start_flag) begin
          st_d   = RUN;
          bkt_d  = dep_q;
          tmr_d  = '0;
          gcnt_d = '0;
        end
      end
      RUN: begin
        if (finish_flag) st_d = IDLE;
        else if (grant)  st_d = XMIT;
      end
      XMIT: begin
        if (send_done)        st_d = finish_flag ? IDLE : RUN;
        else if (finish_flag) st_d = STOP;
      end
      STOP: begin
        if (send_done) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= IDLE;
      per_q   <= TW'(1);
      amt_q   <= TW'(1);
      dep_q   <= TW'(256);
      bkt_q   <= '0;
      tmr_q   <= '0;
      gcnt_q  <= '0;
      grant_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      per_q   <= per_d;
      amt_q   <= amt_d;
      dep_q   <= dep_d;
      bkt_q   <= bkt_d;
      tmr_q   <= tmr_d;
      gcnt_q  <= gcnt_d;
      grant_q <= grant_d;
    end
  end

  assign send_grant   = grant_q;
  assign bucket_level = bkt_q;
  assign grant_cnt    = gcnt_q;
  assign sched_state  = st_q;

endmodule

// File: tb/tb_pgm_tb_sched.sv
// Bench for pgm_tb_sched: directed scenarios plus random traffic
// against an integer reference model of the token-bucket rules.
module tb_pgm_tb_sched;

  logic        clk;
  logic        rst;
  logic        cfg_wr;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic        start_flag;
  logic        finish_flag;
  logic        send_req;
  logic [7:0]  pkt_len;
  logic        in_alf;
  logic        send_grant;
  logic        send_done;
  logic [15:0] bucket_level;
  logic [31:0] grant_cnt;
  logic [1:0]  sched_state;

  pgm_tb_sched #(.TW(16)) dut (
    .clk(clk), .rst(rst),
    .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .start_flag(start_flag), .finish_flag(finish_flag),
    .send_req(send_req), .pkt_len(pkt_len), .in_alf(in_alf),
    .send_grant(send_grant), .send_done(send_done),
    .bucket_level(bucket_level), .grant_cnt(grant_cnt),
    .sched_state(sched_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // send_done source: manual or auto (pulse 3 cycles after a grant)
  logic auto_en;
  logic man_done;
  logic a_done;
  int   a_cnt;
  assign send_done = auto_en ? a_done : man_done;

  always @(negedge clk) begin
    a_done = 1'b0;
    if (!auto_en) a_cnt = 0;
    else begin
      if (a_cnt > 0) begin
        a_cnt--;
        if (a_cnt == 0) a_done = 1'b1;
      end
      if (send_grant === 1'b1) a_cnt = 2;
    end
  end

  // Reference model: modes 0 idle, 1 run, 2 xmit, 3 stopping
  int          m_st, m_bkt, m_tmr, m_per, m_amt, m_dep;
  int unsigned m_cnt;
  int          m_gnt;
  bit          m_ok;
  int          p, c, v, nst, nbkt, ntmr;
  bit          tk, g, act;

  initial m_ok = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_st = 0; m_bkt = 0; m_tmr = 0; m_cnt = 0; m_gnt = 0;
      m_per = 1; m_amt = 1; m_dep = 256;
      m_ok = 1;
    end else begin
      p   = (m_per == 0) ? 1 : m_per;
      act = (m_st != 0);
      tk  = act && (m_tmr == p - 1);
      c   = (pkt_len == 0) ? 1 : int'(pkt_len);
      if (c > m_dep) c = m_dep;
      g   = (m_st == 1) && send_req && !in_alf && !finish_flag
            && (m_bkt >= c);
      nst = m_st; nbkt = m_bkt; ntmr = m_tmr;
      if (act) begin
        ntmr = tk ? 0 : m_tmr + 1;
        v    = m_bkt - (g ? c : 0) + (tk ? m_amt : 0);
        nbkt = (v > m_dep) ? m_dep : v;
      end
      if (g) m_cnt = m_cnt + 1;
      case (m_st)
        0: if (start_flag) begin
             nst = 1; nbkt = m_dep; ntmr = 0; m_cnt = 0;
           end
        1: if (finish_flag) nst = 0; else if (g) nst = 2;
        2: if (send_done) nst = finish_flag ? 0 : 1;
           else if (finish_flag) nst = 3;
        default: if (send_done) nst = 0;
      endcase
      if (m_st == 0 && cfg_wr) begin
        if (cfg_addr == 2'd0) m_per = int'(cfg_wdata & 32'hFFFF);
        if (cfg_addr == 2'd1) m_amt = int'(cfg_wdata & 32'hFFFF);
        if (cfg_addr == 2'd2) m_dep = int'(cfg_wdata & 32'hFFFF);
      end
      m_st = nst; m_bkt = nbkt; m_tmr = ntmr; m_gnt = g ? 1 : 0;
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("m_grant", {63'd0, send_grant}, 64'(m_gnt));
      chk("m_bucket", {48'd0, bucket_level}, 64'(m_bkt));
      chk("m_gcnt", {32'd0, grant_cnt}, 64'(m_cnt));
      chk("m_state", {62'd0, sched_state}, 64'(m_st));
    end
  end

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg(int a, int d);
    cfg_wr = 1'b1; cfg_addr = 2'(a); cfg_wdata = 32'(d);
    step(1);
    cfg_wr = 1'b0;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  task automatic start_run();
    start_flag = 1'b1;
    step(1);
    start_flag = 1'b0;
  endtask

  int n;
  int ng;

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; cfg_wr = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    start_flag = 0; finish_flag = 0; send_req = 0; pkt_len = 0;
    in_alf = 0; auto_en = 0; man_done = 0;
    step(2);
    chk("rst_grant", {63'd0, send_grant}, 64'd0);
    chk("rst_bucket", {48'd0, bucket_level}, 64'd0);
    chk("rst_state", {62'd0, sched_state}, 64'd0);
    chk("rst_gcnt", {32'd0, grant_cnt}, 64'd0);
    rst = 1'b0;

    // Defaults: start loads full bucket
    start_run();
    chk("def_bucket", {48'd0, bucket_level}, 64'd256);
    chk("def_state", {62'd0, sched_state}, 64'd1);
    chk("def_grant", {63'd0, send_grant}, 64'd0);

    // Backpressure holds off a grant
    in_alf = 1; send_req = 1; pkt_len = 8'd4;
    ng = 0;
    repeat (20) begin
      step(1);
      if (send_grant) ng++;
    end
    chk("alf_nogrant", 64'(ng), 64'd0);
    in_alf = 0;
    step(1);
    chk("alf_grant", {63'd0, send_grant}, 64'd1);
    chk("alf_bucket", {48'd0, bucket_level}, 64'd253);
    send_req = 0;
    do_rst();

    // Refill pacing: 8 tokens at 2 per 4 cycles
    cfg(2, 8); cfg(0, 4); cfg(1, 2);
    auto_en = 1; pkt_len = 8'd8; send_req = 1;
    start_run();
    chk("pace_start", {48'd0, bucket_level}, 64'd8);
    step(1);
    chk("pace_g1", {63'd0, send_grant}, 64'd1);
    chk("pace_b1", {48'd0, bucket_level}, 64'd0);
    n = 0;
    do begin
      step(1);
      n++;
    end while (!send_grant && n < 40);
    chk("pace_gap", 64'(n), 64'd16);
    chk("pace_b2", {48'd0, bucket_level}, 64'd0);
    send_req = 0;
    step(5);
    auto_en = 0;
    do_rst();

    // Tick and grant in the same cycle, then finish in XMIT
    cfg(2, 8); cfg(0, 4); cfg(1, 2);
    start_run();
    send_req = 1; pkt_len = 8'd3;
    step(1);
    chk("tg_g1", {63'd0, send_grant}, 64'd1);
    chk("tg_b5", {48'd0, bucket_level}, 64'd5);
    send_req = 0; man_done = 1;
    step(1);
    man_done = 0;
    chk("tg_run", {62'd0, sched_state}, 64'd1);
    step(1);
    send_req = 1;
    step(1);
    chk("tg_g2", {63'd0, send_grant}, 64'd1);
    chk("tg_b4", {48'd0, bucket_level}, 64'd4);
    chk("tg_model", 64'(m_bkt), 64'd4);
    send_req = 0; finish_flag = 1;
    step(1);
    finish_flag = 0;
    chk("stop_state", {62'd0, sched_state}, 64'd3);
    cfg(2, 99);
    chk("stop_hold", {62'd0, sched_state}, 64'd3);
    man_done = 1;
    step(1);
    man_done = 0;
    chk("stop_idle", {62'd0, sched_state}, 64'd0);
    chk("stop_gcnt", {32'd0, grant_cnt}, 64'd2);
    step(3);
    chk("frozen_bkt", {48'd0, bucket_level}, 64'd4);
    start_run();
    chk("cfg_dropped", {48'd0, bucket_level}, 64'd8);
    chk("restart_gcnt", {32'd0, grant_cnt}, 64'd0);
    do_rst();

    // Cost clamps, then reset mid-XMIT
    cfg(2, 8); cfg(1, 0); cfg(0, 0);
    start_run();
    pkt_len = 8'd0; send_req = 1;
    step(1);
    chk("len0_grant", {63'd0, send_grant}, 64'd1);
    chk("len0_bkt", {48'd0, bucket_level}, 64'd7);
    send_req = 0; man_done = 1;
    step(1);
    man_done = 0; finish_flag = 1;
    step(1);
    finish_flag = 0;
    chk("fin_idle", {62'd0, sched_state}, 64'd0);
    start_run();
    pkt_len = 8'd200; send_req = 1;
    step(1);
    chk("len200_grant", {63'd0, send_grant}, 64'd1);
    chk("len200_bkt", {48'd0, bucket_level}, 64'd0);
    chk("len200_xmit", {62'd0, sched_state}, 64'd2);
    rst = 1;
    step(1);
    chk("mr_grant", {63'd0, send_grant}, 64'd0);
    chk("mr_bkt", {48'd0, bucket_level}, 64'd0);
    chk("mr_gcnt", {32'd0, grant_cnt}, 64'd0);
    chk("mr_state", {62'd0, sched_state}, 64'd0);
    rst = 0; pkt_len = 8'd1;
    ng = 0;
    repeat (5) begin
      step(1);
      if (send_grant) ng++;
    end
    chk("mr_nogrant", 64'(ng), 64'd0);
    send_req = 0;

    // Random traffic checked every cycle by the model
    for (int i = 0; i < 4000; i++) begin
      rst         = ($urandom % 400) == 0;
      cfg_wr      = ($urandom % 5) == 0;
      cfg_addr    = 2'($urandom);
      cfg_wdata   = (($urandom % 8) == 0) ? $urandom
                                          : 32'($urandom_range(0, 40));
      start_flag  = ($urandom % ((sched_state == 2'd0) ? 4 : 30)) == 0;
      finish_flag = ($urandom % 60) == 0;
      send_req    = ($urandom % 3) != 0;
      pkt_len     = (($urandom % 4) == 0) ? 8'($urandom)
                                          : 8'($urandom_range(0, 12));
      in_alf      = ($urandom % 5) == 0;
      man_done    = ($urandom % 4) == 0;
      step(1);
    end
    rst = 0; cfg_wr = 0; start_flag = 0; finish_flag = 0;
    send_req = 0; man_done = 0;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
